// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: default field positions, C constant width,
// register-select type and the IR holding FSM encoding.
package cpu_ctrl_pkg;

  localparam int NUM_REGS_DEF = 16;
  localparam int SEL_W_DEF    = $clog2(NUM_REGS_DEF);
  localparam int IR_W_DEF     = 32;
  localparam int RA_LSB_DEF   = 23;
  localparam int RB_LSB_DEF   = 19;
  localparam int RC_LSB_DEF   = 15;
  localparam int C_W_DEF      = 19;

  typedef logic [SEL_W_DEF-1:0] reg_sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } ir_state_e;

endpackage

// File: rtl/onehot_decoder.sv
// Binary to one-hot decoder, purely combinational.
module onehot_decoder #(
  parameter int N = 16,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [W-1:0] bin_i,
  output logic [N-1:0] onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[bin_i] = 1'b1;
  end

endmodule

// File: rtl/reg_select_encode_pipe.sv
// Register-select/encode stage: IR latch, GRA/GRB/GRC decode to Rin/Rout enables,
// C constant sign extension and pending-write scoreboard. Option macro: REG_SELECT_R0_ZERO_EN.
//
// state | meaning
// EMPTY | no IR held yet; enables suppressed, reserve/rin ignored
// HELD  | ir_q valid; selects decode from ir_q
module reg_select_encode_pipe
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int IR_W     = IR_W_DEF,
  parameter int RA_LSB   = RA_LSB_DEF,
  parameter int RB_LSB   = RB_LSB_DEF,
  parameter int RC_LSB   = RC_LSB_DEF,
  parameter int C_W      = C_W_DEF,
  localparam int SEL_W   = $clog2(NUM_REGS)
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                ir_valid_i,
  input  logic [IR_W-1:0]     ir_in_i,
  output logic                ir_ready_o,
  input  logic                gra_i,
  input  logic                grb_i,
  input  logic                grc_i,
  input  logic                rin_i,
  input  logic                rout_i,
  input  logic                baout_i,
  input  logic                reserve_i,
  output logic [NUM_REGS-1:0] rin_onehot_o,
  output logic [NUM_REGS-1:0] rout_onehot_o,
  output logic [SEL_W-1:0]    sel_index_o,
  output logic [31:0]         c_sext_o,
  output logic                hazard_o,
  output logic                sel_err_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic                ba_zero_o
);

  ir_state_e           state_q;
  logic [IR_W-1:0]     ir_q;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] rin_q, rin_d;
  logic [NUM_REGS-1:0] rout_q, rout_d;
  logic [SEL_W-1:0]    sel_q, sel_d, sel_raw;
  logic                hazard_q, hazard_d;
  logic                sel_err_q, sel_err_d;
  logic                ba_zero_q, ba_zero_d;

  logic                held, any_sel, act, rd_req, sel_busy, ba_r0, load;
  logic [NUM_REGS-1:0] dec_rin, dec_rout;
  logic                unused_ir;

  assign held     = (state_q == HELD);
  assign any_sel  = gra_i | grb_i | grc_i;
  assign act      = held & any_sel;
  assign rd_req   = rout_i | baout_i;
  assign sel_raw  = gra_i ? ir_q[RA_LSB +: SEL_W] :
                    grb_i ? ir_q[RB_LSB +: SEL_W] : ir_q[RC_LSB +: SEL_W];
  assign sel_busy = busy_q[sel_raw];

  // No IR swap while the sequencer is driving a select cycle against the held IR.
  assign ir_ready_o = ~held | ~(rin_i | rout_i | baout_i | reserve_i);
  assign load       = ir_valid_i & ir_ready_o;

`ifdef REG_SELECT_R0_ZERO_EN
  assign ba_r0 = baout_i & (sel_raw == '0);
`else
  assign ba_r0 = 1'b0;
`endif

  onehot_decoder #(.N(NUM_REGS)) u_dec_rin  (.bin_i(sel_raw), .onehot_o(dec_rin));
  onehot_decoder #(.N(NUM_REGS)) u_dec_rout (.bin_i(sel_raw), .onehot_o(dec_rout));

  always_comb begin
    rin_d     = (act & rin_i) ? dec_rin : '0;
    rout_d    = (act & rd_req & ~ba_r0 & ~sel_busy) ? dec_rout : '0;
    hazard_d  = act & rd_req & ~ba_r0 & sel_busy;
    ba_zero_d = act & ba_r0;
    sel_d     = act ? sel_raw : '0;
    sel_err_d = (gra_i & grb_i) | (gra_i & grc_i) | (grb_i & grc_i);
    // Clear first so a same-cycle reserve of the same register wins.
    busy_d = busy_q;
    if (act && rin_i)     busy_d[sel_raw] = 1'b0;
    if (act && reserve_i) busy_d[sel_raw] = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= EMPTY;
      ir_q      <= '0;
      busy_q    <= '0;
      rin_q     <= '0;
      rout_q    <= '0;
      sel_q     <= '0;
      hazard_q  <= 1'b0;
      sel_err_q <= 1'b0;
      ba_zero_q <= 1'b0;
    end else begin
      if (load) begin
        ir_q    <= ir_in_i;
        state_q <= HELD;
      end
      busy_q    <= busy_d;
      rin_q     <= rin_d;
      rout_q    <= rout_d;
      sel_q     <= sel_d;
      hazard_q  <= hazard_d;
      sel_err_q <= sel_err_d;
      ba_zero_q <= ba_zero_d;
    end
  end

  assign c_sext_o      = {{(32-C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};
  assign rin_onehot_o  = rin_q;
  assign rout_onehot_o = rout_q;
  assign sel_index_o   = sel_q;
  assign hazard_o      = hazard_q;
  assign sel_err_o     = sel_err_q;
  assign busy_o        = busy_q;
  assign ba_zero_o     = ba_zero_q;

  // Opcode bits above the register fields are consumed by other stages.
  assign unused_ir = ^ir_q;

endmodule

// File: tb/tb_reg_select_encode_pipe.sv
// Self-checking bench for reg_select_encode_pipe: directed cases plus random
// stimulus compared against a behavioural model. Honours REG_SELECT_R0_ZERO_EN.
module tb_reg_select_encode_pipe;

  logic        clock_i = 1'b0;
  logic        reset_i, ir_valid_i, ir_ready_o;
  logic [31:0] ir_in_i, c_sext_o;
  logic        gra_i, grb_i, grc_i, rin_i, rout_i, baout_i, reserve_i;
  logic [15:0] rin_onehot_o, rout_onehot_o, busy_o;
  logic [3:0]  sel_index_o;
  logic        hazard_o, sel_err_o, ba_zero_o;

  always #5 clock_i = ~clock_i;

  reg_select_encode_pipe dut (
    .clock_i(clock_i), .reset_i(reset_i), .ir_valid_i(ir_valid_i), .ir_in_i(ir_in_i),
    .ir_ready_o(ir_ready_o), .gra_i(gra_i), .grb_i(grb_i), .grc_i(grc_i),
    .rin_i(rin_i), .rout_i(rout_i), .baout_i(baout_i), .reserve_i(reserve_i),
    .rin_onehot_o(rin_onehot_o), .rout_onehot_o(rout_onehot_o), .sel_index_o(sel_index_o),
    .c_sext_o(c_sext_o), .hazard_o(hazard_o), .sel_err_o(sel_err_o),
    .busy_o(busy_o), .ba_zero_o(ba_zero_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [31:0] m_ir;
  bit          m_held;
  bit [15:0]   m_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fld(input logic [31:0] ir, input int lsb);
    return int'((ir >> lsb) % 16);
  endfunction

  function automatic logic [31:0] sext19(input logic [31:0] ir);
    int v;
    v = int'(ir % 32'h80000);
    if (v >= 32'h40000) v = v - 32'h80000;
    return 32'(v);
  endfunction

  task automatic cycle(input bit v, input logic [31:0] ir, input bit a, input bit b, input bit c,
                       input bit wi, input bit ro, input bit ba, input bit rs);
    bit        e_ready, e_err, e_haz, e_baz, r0;
    bit [15:0] e_rin, e_rout, nb;
    int        e_idx, s, nsel;
    ir_valid_i = v; ir_in_i = ir; gra_i = a; grb_i = b; grc_i = c;
    rin_i = wi; rout_i = ro; baout_i = ba; reserve_i = rs;
    #1;
    e_ready = !m_held || !(wi || ro || ba || rs);
    check("ir_ready", 32'(ir_ready_o), 32'(e_ready));
    nsel = int'(a) + int'(b) + int'(c);
    e_err = (nsel >= 2);
    e_rin = 0; e_rout = 0; e_haz = 0; e_baz = 0; e_idx = 0; nb = m_busy;
    if (m_held && nsel > 0) begin
      s = a ? fld(m_ir, 23) : (b ? fld(m_ir, 19) : fld(m_ir, 15));
      e_idx = s;
      if (wi) e_rin = 16'(1 << s);
      r0 = 0;
`ifdef REG_SELECT_R0_ZERO_EN
      r0 = ba && (s == 0);
`endif
      if (r0) e_baz = 1;
      else if (ro || ba) begin
        if (m_busy[s]) e_haz = 1;
        else e_rout = 16'(1 << s);
      end
      if (wi) nb[s] = 1'b0;
      if (rs) nb[s] = 1'b1;
    end
    if (v && e_ready) begin
      m_ir = ir;
      m_held = 1;
    end
    @(posedge clock_i);
    #1;
    m_busy = nb;
    check("rin_onehot",  32'(rin_onehot_o),  32'(e_rin));
    check("rout_onehot", 32'(rout_onehot_o), 32'(e_rout));
    check("sel_index",   32'(sel_index_o),   32'(e_idx));
    check("hazard",      32'(hazard_o),      32'(e_haz));
    check("sel_err",     32'(sel_err_o),     32'(e_err));
    check("ba_zero",     32'(ba_zero_o),     32'(e_baz));
    check("busy",        32'(busy_o),        32'(m_busy));
    check("c_sext",      c_sext_o,           sext19(m_ir));
  endtask

  task automatic do_reset(input bit noisy);
    reset_i = 1;
    ir_valid_i = noisy ? 1'($urandom) : 1'b0; ir_in_i = $urandom;
    gra_i = noisy ? 1'($urandom) : 1'b0; grb_i = 0; grc_i = 0;
    rin_i = 0; rout_i = 0; baout_i = 0;
    reserve_i = noisy ? 1'($urandom) : 1'b0;
    @(posedge clock_i);
    #1;
    reset_i = 0;
    m_ir = 0; m_held = 0; m_busy = 0;
    check("rst busy",   32'(busy_o), 32'h0);
    check("rst rin",    32'(rin_onehot_o), 32'h0);
    check("rst rout",   32'(rout_onehot_o), 32'h0);
    check("rst flags",  {29'h0, hazard_o, sel_err_o, ba_zero_o}, 32'h0);
    check("rst sel",    32'(sel_index_o), 32'h0);
    check("rst c_sext", c_sext_o, 32'h0);
    check("rst ready",  32'(ir_ready_o), 32'h1);
  endtask

  initial begin
    logic [31:0] rir;
    do_reset(0);

    // Directed: IR with Ra=5, Rb=3, Rc=0
    cycle(1, 32'h0A980000, 0,0,0, 0,0,0,0);
    cycle(0, 32'h0, 1,0,0, 1,0,0,0);
    check("t1 rin", 32'(rin_onehot_o), 32'h0020);
    check("t1 sel", 32'(sel_index_o), 32'h5);
    cycle(0, 32'h0, 0,1,0, 0,1,0,0);
    check("t2 rout rb", 32'(rout_onehot_o), 32'h0008);
    cycle(0, 32'h0, 0,0,1, 0,1,0,0);
    check("t2 rout rc", 32'(rout_onehot_o), 32'h0001);
    cycle(0, 32'h0, 1,0,0, 0,0,0,1);
    check("t3 busy set", 32'(busy_o), 32'h0020);
    cycle(0, 32'h0, 1,0,0, 0,1,0,0);
    check("t3 hazard", 32'(hazard_o), 32'h1);
    check("t3 rout blocked", 32'(rout_onehot_o), 32'h0);
    cycle(0, 32'h0, 1,0,0, 1,0,0,0);
    check("t3 busy clr", 32'(busy_o), 32'h0);
    cycle(0, 32'h0, 1,0,0, 0,1,0,0);
    check("t3 retry", 32'(rout_onehot_o), 32'h0020);
    cycle(0, 32'h0, 1,0,0, 1,0,0,1);
    check("t4 set wins", 32'(busy_o), 32'h0020);
    cycle(0, 32'h0, 1,1,0, 1,0,0,0);
    check("t4 sel_err", 32'(sel_err_o), 32'h1);
    check("t4 ra wins", 32'(rin_onehot_o), 32'h0020);
    cycle(1, 32'h00040000, 0,0,0, 0,0,0,0);
    check("t5 neg c", c_sext_o, 32'hFFFC0000);
    cycle(1, 32'h0003FFFF, 0,0,0, 0,0,0,0);
    check("t5 pos c", c_sext_o, 32'h0003FFFF);
    cycle(1, 32'h0A980000, 0,0,0, 0,0,0,0);
    cycle(0, 32'h0, 0,0,1, 0,0,1,0);
`ifdef REG_SELECT_R0_ZERO_EN
    check("t6 ba_zero", 32'(ba_zero_o), 32'h1);
    check("t6 rout", 32'(rout_onehot_o), 32'h0);
`else
    check("t6 ba_zero", 32'(ba_zero_o), 32'h0);
    check("t6 rout", 32'(rout_onehot_o), 32'h0001);
`endif
    cycle(0, 32'h0, 0,1,0, 0,0,0,1);
    check("t6 busy pre", 32'(busy_o), 32'h0008);
    do_reset(1);

    // Random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(1);
      end else begin
        rir = $urandom;
        if ($urandom_range(0, 1) == 1) rir = rir & ~32'h06318000;
        cycle($urandom_range(0, 3) == 0, rir,
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
